// File: rtl/fetch_buf_pkg.sv
// fetch_buf_pkg: shared widths, reset address and NOP encoding for the prefetch buffer.
// Revision 1.0
`default_nettype none

package fetch_buf_pkg;
  localparam int unsigned       c_ilen     = 32;
  localparam logic [c_ilen-1:0] c_reset_pc = 32'h0000_0000;
  localparam logic [c_ilen-1:0] c_nop      = 32'h0000_0013;
endpackage

`default_nettype wire

// File: rtl/fetch_buf_if.sv
// fetch_buf_if: redirect, instruction-memory and decode-side handshakes of the fetch buffer.
// Revision 1.0
`default_nettype none

interface fetch_buf_if
  import fetch_buf_pkg::*;
#(
  parameter int unsigned XLEN = c_ilen
) ();
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_ir;

  modport master (
    input  redir_valid, redir_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_ir
  );

  modport slave (
    output redir_valid, redir_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_ir
  );
endinterface

`default_nettype wire

// File: rtl/fetch_buf_fifo.sv
// fetch_buf_fifo: synchronous FIFO with wrap-bit pointers and a flush that empties it next cycle.
// Revision 1.0
`default_nettype none

module fetch_buf_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw:0]    wr_ptr_q, wr_ptr_d;
  logic [c_aw:0]    rd_ptr_q, rd_ptr_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[c_aw-1:0]];

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & ~flush_i & (~full_o | w_do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[c_aw-1:0]] <= wdata_i;
  end
endmodule

`default_nettype wire

// File: rtl/fetch_buf.sv
// fetch_buf: instruction prefetch queue with in-order memory fetch and branch-redirect discard.
// Revision 1.0
`default_nettype none

module fetch_buf
  import fetch_buf_pkg::*;
#(
  parameter int unsigned     XLEN     = c_ilen,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_reset_pc)
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_buf_if.master  bus
);
  localparam int unsigned     c_aw    = $clog2(DEPTH);
  localparam logic [c_aw+1:0] c_depth = (c_aw+2)'(DEPTH);
  localparam logic [XLEN-1:0] c_step  = XLEN'(4);
  localparam logic [XLEN-1:0] c_align = ~XLEN'(3);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [c_aw:0]     outst_q, outst_d;
  logic [c_aw:0]     discard_q, discard_d;
  logic [c_aw:0]     w_q_count;
  logic [c_aw+1:0]   w_inflight;
  logic [2*XLEN-1:0] w_q_wdata, w_q_rdata;
  logic [XLEN-1:0]   w_redir_pc;
  logic              w_req_fire, w_rsp_fire, w_drop, w_push, w_pop;
  logic              w_full, w_empty;

  assign w_redir_pc = bus.redir_pc & c_align;
  assign w_inflight = {1'b0, w_q_count} + {1'b0, outst_q};

  // Queued plus outstanding never exceeds DEPTH, so every response has a free slot.
  assign bus.imem_req_valid = rst_n & ~bus.redir_valid & (w_inflight < c_depth);
  assign bus.imem_req_addr  = fetch_pc_q & c_align;

  assign w_req_fire = bus.imem_req_valid & bus.imem_req_ready;
  assign w_rsp_fire = bus.imem_rsp_valid;
  assign w_drop     = (discard_q != '0);
  assign w_push     = w_rsp_fire & ~w_drop & ~bus.redir_valid & ~w_full;
  assign w_pop      = ~w_empty & bus.out_ready;
  assign w_q_wdata  = {rsp_pc_q, bus.imem_rsp_data};

  assign bus.out_valid = ~w_empty;
  assign bus.out_pc    = w_empty ? '0 : w_q_rdata[2*XLEN-1:XLEN];
  assign bus.out_ir    = w_empty ? '0 : w_q_rdata[XLEN-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    outst_d    = outst_q + (c_aw+1)'(w_req_fire) - (c_aw+1)'(w_rsp_fire);
    if (bus.redir_valid) begin
      // Everything still in flight belongs to the abandoned path, including any earlier discards.
      fetch_pc_d = w_redir_pc;
      rsp_pc_d   = w_redir_pc;
      discard_d  = outst_q - (c_aw+1)'(w_rsp_fire);
    end else begin
      if (w_req_fire) fetch_pc_d = fetch_pc_q + c_step;
      if (w_rsp_fire) begin
        if (w_drop) discard_d = discard_q - 1'b1;
        else        rsp_pc_d  = rsp_pc_q + c_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_buf_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .wdata_i (w_q_wdata),
    .pop_i   (w_pop),
    .flush_i (bus.redir_valid),
    .rdata_o (w_q_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_q_count)
  );
endmodule

`default_nettype wire

// File: tb/tb_fetch_buf.sv
// tb_fetch_buf: directed and randomised stimulus with a PC/instruction scoreboard for fetch_buf.
// Revision 1.0
`default_nettype none

module tb_fetch_buf;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned DEPTH       = 4;
  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   chk_cnt  = 0;
  int   edges    = 0;
  int   mem_lat  = 1;
  logic [31:0] model_pc = TB_RESET_PC;
  exp_t  exp_q[$];
  mreq_t mq[$];

  fetch_buf_if #(.XLEN(XLEN)) bus ();

  fetch_buf #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (TB_RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_out(input logic [31:0] pc, input string tag);
    int n;
    bit xfer;
    n = 0;
    xfer = 1'b0;
    while (!xfer && n < 60) begin
      @(negedge clk);
      n++;
      xfer = bus.out_valid && bus.out_ready;
    end
    check({tag, "_xfer"}, 32'(xfer), 32'd1);
    check(tag, bus.out_pc, pc);
  endtask

  // Memory: in-order responses, each returned mem_lat cycles after its request was accepted.
  always begin
    @(posedge clk);
    #1;
    edges++;
    if (!rst_n) begin
      bus.imem_rsp_valid = 1'b0;
    end else begin
      if (bus.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (mq.size() > 0 && mq[0].due <= edges + 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mq[0].addr);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    mq.delete();
    model_pc = TB_RESET_PC;
  end

  // Scoreboard: expected entries pushed per accepted request, popped per output transfer.
  always @(negedge clk) begin : mon
    int    stale;
    logic  exp_req;
    exp_t  e;
    mreq_t m;
    if (rst_n) begin
      stale = 0;
      foreach (mq[i]) if (mq[i].stale) stale++;
      exp_req = !bus.redir_valid && (exp_q.size() + stale < DEPTH);
      check("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          check("out_pc", bus.out_pc, exp_q[0].pc);
          check("out_ir", bus.out_ir, exp_q[0].ir);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.redir_valid) begin
        exp_q.delete();
        foreach (mq[i]) mq[i].stale = 1'b1;
        model_pc = bus.redir_pc & 32'hFFFF_FFFC;
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("req_addr", bus.imem_req_addr, model_pc);
        e.pc = model_pc;
        e.ir = mem_word(model_pc);
        exp_q.push_back(e);
        m.addr  = bus.imem_req_addr;
        m.due   = edges + 1 + mem_lat;
        m.stale = 1'b0;
        mq.push_back(m);
        model_pc = model_pc + 32'd4;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int reqs;
    bus.redir_valid    = 1'b0;
    bus.redir_pc       = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.out_ready      = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_ir", bus.out_ir, 32'd0);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("first_req_addr", bus.imem_req_addr, TB_RESET_PC);
    @(negedge clk);
    check("out_valid_early", 32'(bus.out_valid), 32'd0);
    // One instruction per cycle, crossing the 2^32 wrap.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("stream_valid", 32'(bus.out_valid), 32'd1);
      check("stream_pc", bus.out_pc, TB_RESET_PC + 32'(4 * i));
    end

    @(posedge clk); #1 bus.out_ready = 1'b0;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) reqs++;
    end
    check("stall_reqs_le_depth", 32'(reqs <= int'(DEPTH)), 32'd1);
    check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    check("stall_hold_pc", bus.out_pc, TB_RESET_PC + 32'd48);
    check("stall_hold_ir", bus.out_ir, mem_word(TB_RESET_PC + 32'd48));
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_out(TB_RESET_PC + 32'd48, "resume");

    mem_lat = 3;
    repeat (12) @(negedge clk);
    @(posedge clk); #1 begin bus.redir_valid = 1'b1; bus.redir_pc = 32'h0000_0100; end
    @(posedge clk); #1 bus.redir_valid = 1'b0;
    wait_out(32'h0000_0100, "redir_100");

    repeat (4) @(negedge clk);
    @(posedge clk); #1 begin bus.redir_valid = 1'b1; bus.redir_pc = 32'h0000_0300; end
    @(posedge clk); #1 bus.redir_pc = 32'h0000_0203;
    @(posedge clk); #1 bus.redir_valid = 1'b0;
    @(negedge clk);
    check("redir_aligned_addr", bus.imem_req_addr, 32'h0000_0200);
    wait_out(32'h0000_0200, "redir_203");

    mem_lat = 1;
    repeat (8) @(negedge clk);
    @(posedge clk); #1 begin bus.redir_valid = 1'b1; bus.redir_pc = 32'h0000_0000; end
    @(posedge clk); #1 bus.redir_valid = 1'b0;
    wait_out(32'h0000_0000, "zero_pc0");
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check("zero_stream_valid", 32'(bus.out_valid), 32'd1);
      check("zero_stream_pc", bus.out_pc, 32'(4 * i));
    end

    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (i % 50 == 0) mem_lat = int'($urandom_range(1, 3));
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.imem_req_ready = ($urandom_range(0, 4) != 0);
      bus.redir_valid    = ($urandom_range(0, 19) == 0);
      bus.redir_pc       = 32'($urandom_range(0, 1023));
    end
    @(posedge clk); #1 begin
      bus.out_ready = 1'b1; bus.imem_req_ready = 1'b1; bus.redir_valid = 1'b0;
    end

    mem_lat = 2;
    repeat (10) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("midrst_out_pc", bus.out_pc, 32'd0);
    check("midrst_out_ir", bus.out_ir, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_out(TB_RESET_PC, "restart");
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fetch_buf.md
FETCH_BUF -- requirements
Module: fetch_buf

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 32, address and instruction width.
- DEPTH, 4, prefetch queue entries (power of two, 2..16).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- redir_valid, in, 1, EX-stage taken branch/jump.
- redir_pc, in, XLEN, redirect target.
- imem_req_valid, out, 1, fetch request.
- imem_req_ready, in, 1, memory accepts request.
- imem_req_addr, out, XLEN, word-aligned fetch address.
- imem_rsp_valid, in, 1, instruction returned (in order, one per accepted request, latency >= 1).
- imem_rsp_data, in, XLEN, instruction word.
- out_valid, out, 1, decode-side instruction available.
- out_ready, in, 1, decode accepts (low = stall).
- out_pc, out, XLEN, PC of presented instruction.
- out_ir, out, XLEN, presented instruction.

Function
REQ-003 A request SHALL transfer on any cycle with imem_req_valid and imem_req_ready both high; a response SHALL transfer on any cycle with imem_rsp_valid high; an output SHALL transfer on any cycle with out_valid and out_ready both high.
REQ-004 Register fetch_pc SHALL hold the next request address; imem_req_addr = fetch_pc, bits [1:0] always 0.
REQ-005 imem_req_valid SHALL be high iff redir_valid is low and (queue count + outstanding count) < DEPTH.
REQ-006 Each request transfer SHALL advance fetch_pc by 4, with modulo-2^XLEN wrap (32'hFFFF_FFFC -> 0).
REQ-007 Outstanding count (0..DEPTH) SHALL increment on request transfer, decrement on response transfer; simultaneous events leave it unchanged.
REQ-008 A non-discarded response SHALL be written to the queue tail with its PC (a PC shadow FIFO or tail-PC counter) and SHALL become visible on out_* no earlier than the following cycle; minimum request-to-out_valid latency = memory latency + 1.
REQ-009 out_valid = queue non-empty; out_pc/out_ir SHALL show the head entry and hold stable while out_valid is high and out_ready is low.
REQ-010 Queue SHALL never overflow (guaranteed by REQ-005); simultaneous write and read when full or empty SHALL be handled correctly, with no bypass of an empty queue.
REQ-011 On redir_valid: the queue SHALL be emptied next cycle; fetch_pc <= {redir_pc[XLEN-1:2],2'b00}; no request that cycle; the discard counter SHALL be loaded with outstanding count minus 1 if a response transfers that cycle, else outstanding count, and that response SHALL be dropped.
REQ-012 While discard counter > 0, each response SHALL be dropped and decrement the counter instead of being enqueued.
REQ-013 An output transfer coinciding with redir_valid SHALL complete normally; the redirect takes precedence over any simultaneous enqueue.
REQ-014 Back-to-back redirects SHALL each reload fetch_pc; the discard counter SHALL accumulate correctly (no stale instruction ever reaches out_*).
REQ-015 Steady state with out_ready high and single-cycle memory SHALL sustain one instruction per cycle.

Reset
REQ-016 rst_n low SHALL immediately force: fetch_pc = RESET_PC, queue empty, outstanding = 0, discard = 0, out_valid = 0, imem_req_valid = 0, out_pc = 0, out_ir = 0.
REQ-017 First request SHALL issue in the first cycle after rst_n deasserts; reset mid-operation abandons all in-flight responses (the memory is reset with the same rst_n).

Structure
REQ-018 Shared definitions file SHALL hold RESET_PC default, the NOP encoding (32'h0000_0013), and the instruction width constant.
REQ-019 Queue SHALL be one sub-module fetch_buf_fifo (parameters WIDTH, DEPTH; push, pop, flush, full, empty, count); pointers SHALL be log2(DEPTH)+1 bits with wrap.

Verification
REQ-020 Reset, 1-cycle memory, out_ready=1 -> out_pc sequence 0,4,8,... one per cycle, out_valid first high in the 2nd cycle after reset release.
REQ-021 out_ready=0 for 10 cycles, DEPTH=4 -> at most 4 requests issued and then imem_req_valid low; out_pc/out_ir held; release -> PCs resume in order with none lost.
REQ-022 3-cycle memory latency, redirect to 32'h0000_0100 with 3 outstanding -> 3 responses dropped, next out_pc = 32'h100.
REQ-023 redir_pc = 32'h0000_0203 -> imem_req_addr = 32'h0000_0200.
REQ-024 RESET_PC = 32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0, 4.
REQ-025 rst_n pulsed low mid-stream with 2 outstanding -> outputs zeroed asynchronously, restart at RESET_PC, no stale instruction presented.
